// File: rtl/matrix_loader_pkg.sv
// Shared types and constants for the matrix operand loader and its index counter.
// The flat operand always uses a row stride of MAX_DIM, whatever the active size.
package matrix_loader_pkg;

  localparam int ELEM_W  = 8;
  localparam int MAX_DIM = 5;
  localparam int FLAT_W  = MAX_DIM * MAX_DIM * ELEM_W;

  localparam logic [2:0] SIZE_NONE = 3'b000;
  localparam logic [2:0] SIZE_2X2  = 3'b010;
  localparam logic [2:0] SIZE_3X3  = 3'b011;
  localparam logic [2:0] SIZE_4X4  = 3'b100;
  localparam logic [2:0] SIZE_5X5  = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SETTLE,
    WAIT,
    RESULT
  } state_t;

  // Slot of element (r,c) inside the flat operand, in units of ELEM_W.
  function automatic logic [4:0] slot_index(input logic [2:0] r, input logic [2:0] c);
    return ({2'b00, r} * 5'd5) + {2'b00, c};
  endfunction

  function automatic logic size_is_legal(input logic [2:0] s);
    return (s >= SIZE_2X2) && (s <= SIZE_5X5);
  endfunction

endpackage

// File: rtl/matrix_operand_loader_if.sv
// Host-side command, element and result handshakes of the matrix operand loader.
// Every channel transfers on a rising clock edge where valid && ready are both high;
// the sender holds its payload stable while valid is high and ready is low.
interface matrix_operand_loader_if;

  logic                               cmd_valid;
  logic                               cmd_ready;
  logic [2:0]                         cmd_size;

  logic                               in_valid;
  logic                               in_ready;
  logic [matrix_loader_pkg::ELEM_W-1:0] in_data;

  logic                               res_valid;
  logic                               res_ready;
  logic [matrix_loader_pkg::ELEM_W-1:0] res_number;
  logic                               res_overflow;
  logic                               res_error;

  modport master (
    output cmd_valid, cmd_size, in_valid, in_data, res_ready,
    input  cmd_ready, in_ready, res_valid, res_number, res_overflow, res_error
  );

  modport slave (
    input  cmd_valid, cmd_size, in_valid, in_data, res_ready,
    output cmd_ready, in_ready, res_valid, res_number, res_overflow, res_error
  );

endinterface

// File: rtl/matrix_index_counter.sv
// Row-major (row,col) walker over an n x n matrix; last flags the final element.
module matrix_index_counter (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       advance,
  input  logic [2:0] n,
  output logic [2:0] row,
  output logic [2:0] col,
  output logic       last
);

  logic [2:0] n_m1;

  assign n_m1 = n - 3'd1;
  assign last = (row == n_m1) && (col == n_m1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      row <= 3'd0;
      col <= 3'd0;
    end else if (advance) begin
      if (col == n_m1) begin
        col <= 3'd0;
        row <= row + 3'd1;
      end else begin
        col <= col + 3'd1;
      end
    end
  end

endmodule

// File: rtl/matrix_operand_loader.sv
// Front end for the determinant ALU: takes a size command and row-major elements,
// presents the packed operand, waits for done (or a timeout) and returns the result.
module matrix_operand_loader
  import matrix_loader_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  matrix_operand_loader_if.slave bus,
  output logic [FLAT_W-1:0]   A_flat,
  output logic [2:0]          matrix_size,
  input  logic [ELEM_W-1:0]   det_number,
  input  logic                det_done,
  input  logic                det_overflow,
  output logic                busy,
  output state_t              state_dbg
);

  localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t              state_q, state_d;
  logic [2:0]          n_q;
  logic [FLAT_W-1:0]   a_flat_q;
  logic [15:0]         cnt_q;
  logic [ELEM_W-1:0]   res_number_q;
  logic                res_overflow_q;
  logic                res_error_q;

  logic                cmd_ok, cmd_bad, elem_wr, capture, time_out;
  logic                cnt_clr, cnt_inc;
  logic [2:0]          idx_row, idx_col;
  logic                idx_last;

  matrix_index_counter u_index (
    .clock   (clock),
    .reset   (reset),
    .clear   (cmd_ok),
    .advance (elem_wr),
    .n       (n_q),
    .row     (idx_row),
    .col     (idx_col),
    .last    (idx_last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cmd_ok   = 1'b0;
    cmd_bad  = 1'b0;
    elem_wr  = 1'b0;
    capture  = 1'b0;
    time_out = 1'b0;
    cnt_clr  = 1'b0;
    cnt_inc  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          if (size_is_legal(bus.cmd_size)) begin
            cmd_ok  = 1'b1;
            cnt_clr = 1'b1;
            state_d = LOAD;
          end else begin
            cmd_bad = 1'b1;
            state_d = RESULT;
          end
        end
      end
      LOAD: begin
        if (bus.in_valid) begin
          elem_wr = 1'b1;
          if (idx_last) begin
            cnt_clr = 1'b1;
            state_d = SETTLE;
          end
        end
      end
      // det_done is deliberately not looked at here: it may still be left over from
      // a previous operand until the ALU has seen the new size for a while.
      SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_clr = 1'b1;
          state_d = WAIT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      WAIT: begin
        if (det_done) begin
          capture = 1'b1;
          state_d = RESULT;
        end else if (cnt_q == TIMEOUT_LAST) begin
          time_out = 1'b1;
          state_d  = RESULT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      RESULT: begin
        if (bus.res_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      n_q            <= SIZE_NONE;
      a_flat_q       <= '0;
      cnt_q          <= 16'd0;
      res_number_q   <= '0;
      res_overflow_q <= 1'b0;
      res_error_q    <= 1'b0;
    end else begin
      if (cmd_ok) begin
        n_q      <= bus.cmd_size;
        a_flat_q <= '0;
      end
      if (elem_wr) begin
        a_flat_q[ELEM_W*int'(slot_index(idx_row, idx_col)) +: ELEM_W] <= bus.in_data;
      end
      if (cnt_clr) begin
        cnt_q <= 16'd0;
      end else if (cnt_inc) begin
        cnt_q <= cnt_q + 16'd1;
      end
      if (cmd_bad || time_out) begin
        res_number_q   <= '0;
        res_overflow_q <= 1'b0;
        res_error_q    <= 1'b1;
      end else if (capture) begin
        res_number_q   <= det_number;
        res_overflow_q <= det_overflow;
        res_error_q    <= 1'b0;
      end
    end
  end

  // The size code is only offered while the operand is frozen for the ALU.
  assign matrix_size      = ((state_q == SETTLE) || (state_q == WAIT)) ? n_q : SIZE_NONE;
  assign A_flat           = a_flat_q;
  assign bus.cmd_ready    = (state_q == IDLE);
  assign bus.in_ready     = (state_q == LOAD);
  assign bus.res_valid    = (state_q == RESULT);
  assign bus.res_number   = res_number_q;
  assign bus.res_overflow = res_overflow_q;
  assign bus.res_error    = res_error_q;
  assign busy             = (state_q != IDLE);
  assign state_dbg        = state_q;

endmodule
